// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared encoder constants, binder shift table and scheduler types
package enc_pkg;

  localparam int NUM_PACKS  = 64;
  localparam int PACK_WIDTH = 10;

  // Per-lane rotation applied by every binder pack; lane i of a pack uses SHIFTS[i].
  localparam int SHIFTS [PACK_WIDTH] = '{0, 7, 13, 19, 29, 37, 43, 53, 61, 71};

  typedef logic [$clog2(NUM_PACKS)-1:0] pack_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    DRAIN,
    DONE
  } enc_sched_state_t;

endpackage

// File: rtl/enc_sched_pipe.sv
// rtl/enc_sched_pipe.sv - fixed-depth valid+pack index delay line; depth 0 is a wire
module enc_sched_pipe #(
  parameter int DEPTH = 1,
  parameter int IW    = 6
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          i_valid,
  input  logic [IW-1:0] i_idx,
  output logic          o_valid,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign o_valid = i_valid;
      assign o_idx   = i_idx;
      assign o_any   = 1'b0;
    end else begin : g_reg
      logic [DEPTH-1:0] r_vld;
      logic [IW-1:0]    r_idx [DEPTH];

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          r_vld <= '0;
          for (int i = 0; i < DEPTH; i++) r_idx[i] <= '0;
        end else begin
          r_vld[0] <= i_valid;
          r_idx[0] <= i_valid ? i_idx : '0;
          for (int i = 1; i < DEPTH; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_idx[i] <= r_idx[i-1];
          end
        end
      end

      assign o_valid = r_vld[DEPTH-1];
      assign o_idx   = r_idx[DEPTH-1];

      // Only entries that have not yet reached the output stage still count as in flight.
      if (DEPTH == 1) begin : g_any_none
        assign o_any = 1'b0;
      end else begin : g_any_or
        assign o_any = |r_vld[DEPTH-2:0];
      end
    end
  endgenerate

endmodule

// File: rtl/enc_pack_sched.sv
// rtl/enc_pack_sched.sv - per-sample sequencer: clear accumulator, issue level reads, start packs, accumulate
module enc_pack_sched #(
  parameter int NUM_PACKS  = enc_pkg::NUM_PACKS,
  parameter int PACK_WIDTH = enc_pkg::PACK_WIDTH,
  parameter int LVL_RD_LAT = 1,
  parameter int BIND_LAT   = 1
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic                         issue_hold,
  output logic                         lvl_rd_en,
  output logic [$clog2(NUM_PACKS)-1:0] lvl_rd_pack,
  output logic [NUM_PACKS-1:0]         pack_start,
  output logic                         acc_clr,
  output logic                         acc_en,
  output logic [$clog2(NUM_PACKS)-1:0] acc_sel,
  output logic                         enc_valid,
  input  logic                         enc_ready,
  output logic                         busy
);

  import enc_pkg::*;

  localparam int            IW       = $clog2(NUM_PACKS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PACKS - 1);

  generate
    if (LVL_RD_LAT < 0 || LVL_RD_LAT > 4 || BIND_LAT < 1 || BIND_LAT > 4 || PACK_WIDTH < 1)
    begin : g_param_check
      $error("enc_pack_sched: latency or pack-width parameter out of range");
    end
  endgenerate

  enc_sched_state_t r_state;
  enc_sched_state_t w_next;
  logic [IW-1:0]    r_cnt;
  logic             w_issue;
  logic             w_drained;

  logic             w_p1_valid;
  logic [IW-1:0]    w_p1_idx;
  logic             w_p1_any;
  logic             w_p2_valid;
  logic [IW-1:0]    w_p2_idx;
  logic             w_p2_any;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Nothing left that can still produce a start pulse or an accumulate after this cycle.
  assign w_drained = !w_p1_any && !w_p1_valid && !w_p2_any;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (sample_valid) w_next = CLEAR;
      CLEAR:   w_next = ISSUE;
      ISSUE:   if (!issue_hold && r_cnt == LAST_IDX) w_next = DRAIN;
      DRAIN:   if (w_drained) w_next = DONE;
      DONE:    if (enc_ready) w_next = sample_valid ? CLEAR : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    sample_ready = 1'b0;
    acc_clr      = 1'b0;
    enc_valid    = 1'b0;
    busy         = 1'b1;
    w_issue      = 1'b0;
    case (r_state)
      IDLE: begin
        sample_ready = 1'b1;
        busy         = 1'b0;
      end
      CLEAR:   acc_clr = 1'b1;
      ISSUE:   w_issue = !issue_hold;
      DONE: begin
        enc_valid    = 1'b1;
        sample_ready = enc_ready;
      end
      default: ;
    endcase
    lvl_rd_en   = w_issue;
    lvl_rd_pack = w_issue ? r_cnt : '0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (w_issue) begin
      r_cnt <= (r_cnt == LAST_IDX) ? '0 : r_cnt + 1'b1;
    end
  end

  enc_sched_pipe #(
    .DEPTH (LVL_RD_LAT),
    .IW    (IW)
  ) u_rd_pipe (
    .clk     (clk),
    .nrst    (nrst),
    .i_valid (lvl_rd_en),
    .i_idx   (lvl_rd_pack),
    .o_valid (w_p1_valid),
    .o_idx   (w_p1_idx),
    .o_any   (w_p1_any)
  );

  enc_sched_pipe #(
    .DEPTH (BIND_LAT),
    .IW    (IW)
  ) u_bind_pipe (
    .clk     (clk),
    .nrst    (nrst),
    .i_valid (w_p1_valid),
    .i_idx   (w_p1_idx),
    .o_valid (w_p2_valid),
    .o_idx   (w_p2_idx),
    .o_any   (w_p2_any)
  );

  assign pack_start = w_p1_valid ? (NUM_PACKS'(1) << w_p1_idx) : '0;
  assign acc_en     = w_p2_valid;
  assign acc_sel    = w_p2_idx;

endmodule
